// File: rtl/spk_out_arb.sv
// Two-requester arbiter sharing one spk_out write port between config-readback and spike
// flit streams: per-requester FIFOs drained by a bounded-burst round-robin scheduler.
module spk_out_arb #(
    parameter int FW    = 59,
    parameter int DEPTH = 2,
    parameter int BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [FW-1:0] cfg_wdata,
    output logic          cfg_full,
    input  logic          spk_we,
    input  logic [FW-1:0] spk_wdata,
    output logic          spk_full,
    input  logic          out_full,
    output logic          out_we,
    output logic [FW-1:0] out_wdata,
    output logic          arb_busy,
    output logic          cfg_ovf,
    output logic          spk_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(BURST + 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [BW-1:0] BURST_MAX = BW'(BURST);
    localparam logic [BW-1:0] BURST_ONE = BW'(1);
    localparam logic [0:0]    GNT_CFG   = 1'b0;
    localparam logic [0:0]    GNT_SPK   = 1'b1;

    logic [FW-1:0] cfg_mem_r [DEPTH];
    logic [FW-1:0] spk_mem_r [DEPTH];
    logic [AW-1:0] cfg_wptr_r, cfg_rptr_r, spk_wptr_r, spk_rptr_r;
    logic [CW-1:0] cfg_cnt_r, spk_cnt_r, cfg_cnt_nxt_s, spk_cnt_nxt_s;
    logic          cfg_full_r, spk_full_r, cfg_ovf_r, spk_ovf_r;
    logic          out_we_r;
    logic [FW-1:0] out_wdata_r;
    logic [0:0]    last_grant_r, last_nxt_s, grantee_s;
    logic [BW-1:0] burst_cnt_r, burst_nxt_s;
    logic          cfg_push_s, spk_push_s, cfg_ne_s, spk_ne_s;
    logic          grant_cfg_s, grant_spk_s;

    function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] cnt,
                                               input logic push, input logic pop);
        logic [CW-1:0] res;
        case ({push, pop})
            2'b10:   res = cnt + CNT_ONE;
            2'b01:   res = cnt - CNT_ONE;
            default: res = cnt;
        endcase
        return res;
    endfunction

    // FIFO status and push qualification
    always_comb begin
        cfg_push_s    = cfg_we & ~cfg_full_r;
        spk_push_s    = spk_we & ~spk_full_r;
        cfg_ne_s      = (cfg_cnt_r != {CW{1'b0}});
        spk_ne_s      = (spk_cnt_r != {CW{1'b0}});
        cfg_cnt_nxt_s = cnt_next(cfg_cnt_r, cfg_push_s, grant_cfg_s);
        spk_cnt_nxt_s = cnt_next(spk_cnt_r, spk_push_s, grant_spk_s);
    end

    // Round-robin grant with bounded burst; contention favours the last grantee until BURST
    always_comb begin
        grant_cfg_s = 1'b0;
        grant_spk_s = 1'b0;
        if (out_full) begin
            grant_cfg_s = 1'b0;
            grant_spk_s = 1'b0;
        end else if (cfg_ne_s && spk_ne_s) begin
            if (burst_cnt_r < BURST_MAX) begin
                grant_cfg_s = (last_grant_r == GNT_CFG);
                grant_spk_s = (last_grant_r == GNT_SPK);
            end else begin
                grant_cfg_s = (last_grant_r == GNT_SPK);
                grant_spk_s = (last_grant_r == GNT_CFG);
            end
        end else begin
            grant_cfg_s = cfg_ne_s;
            grant_spk_s = spk_ne_s;
        end
    end

    // Burst counter and last-grant bookkeeping
    always_comb begin
        grantee_s   = grant_spk_s ? GNT_SPK : GNT_CFG;
        burst_nxt_s = burst_cnt_r;
        last_nxt_s  = last_grant_r;
        if (grant_cfg_s || grant_spk_s) begin
            last_nxt_s = grantee_s;
            if (grantee_s == last_grant_r) begin
                burst_nxt_s = (burst_cnt_r == BURST_MAX) ? BURST_MAX : burst_cnt_r + BURST_ONE;
            end else begin
                burst_nxt_s = BURST_ONE;
            end
        end else if (!out_full) begin
            burst_nxt_s = {BW{1'b0}};
        end else begin
            burst_nxt_s = burst_cnt_r;
        end
    end

    // Config FIFO storage and pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) cfg_mem_r[i] <= {FW{1'b0}};
            cfg_wptr_r <= {AW{1'b0}};
            cfg_rptr_r <= {AW{1'b0}};
            cfg_cnt_r  <= {CW{1'b0}};
            cfg_full_r <= 1'b0;
            cfg_ovf_r  <= 1'b0;
        end else begin
            if (cfg_push_s) begin
                cfg_mem_r[cfg_wptr_r] <= cfg_wdata;
                cfg_wptr_r            <= cfg_wptr_r + PTR_ONE;
            end
            if (grant_cfg_s) cfg_rptr_r <= cfg_rptr_r + PTR_ONE;
            cfg_cnt_r  <= cfg_cnt_nxt_s;
            cfg_full_r <= (cfg_cnt_nxt_s == CNT_FULL);
            cfg_ovf_r  <= cfg_ovf_r | (cfg_we & cfg_full_r);
        end
    end

    // Spike FIFO storage and pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) spk_mem_r[i] <= {FW{1'b0}};
            spk_wptr_r <= {AW{1'b0}};
            spk_rptr_r <= {AW{1'b0}};
            spk_cnt_r  <= {CW{1'b0}};
            spk_full_r <= 1'b0;
            spk_ovf_r  <= 1'b0;
        end else begin
            if (spk_push_s) begin
                spk_mem_r[spk_wptr_r] <= spk_wdata;
                spk_wptr_r            <= spk_wptr_r + PTR_ONE;
            end
            if (grant_spk_s) spk_rptr_r <= spk_rptr_r + PTR_ONE;
            spk_cnt_r  <= spk_cnt_nxt_s;
            spk_full_r <= (spk_cnt_nxt_s == CNT_FULL);
            spk_ovf_r  <= spk_ovf_r | (spk_we & spk_full_r);
        end
    end

    // Registered write port and scheduler state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_we_r     <= 1'b0;
            out_wdata_r  <= {FW{1'b0}};
            last_grant_r <= GNT_SPK;
            burst_cnt_r  <= {BW{1'b0}};
        end else begin
            out_we_r <= grant_cfg_s | grant_spk_s;
            if (grant_cfg_s) begin
                out_wdata_r <= cfg_mem_r[cfg_rptr_r];
            end else if (grant_spk_s) begin
                out_wdata_r <= spk_mem_r[spk_rptr_r];
            end else begin
                out_wdata_r <= out_wdata_r;
            end
            last_grant_r <= last_nxt_s;
            burst_cnt_r  <= burst_nxt_s;
        end
    end

    assign cfg_full  = cfg_full_r;
    assign spk_full  = spk_full_r;
    assign cfg_ovf   = cfg_ovf_r;
    assign spk_ovf   = spk_ovf_r;
    assign out_we    = out_we_r;
    assign out_wdata = out_wdata_r;
    assign arb_busy  = cfg_ne_s | spk_ne_s | out_we_r;
endmodule

// File: tb/tb_spk_out_arb.sv
// Directed bench for spk_out_arb: a per-cycle vector table plus hand-written sequences
// for reset, burst fairness, back-pressure, overflow and steady push/pop.
module tb_spk_out_arb;
    localparam int FW = 59;

    logic          clk, rst;
    logic          cfg_we, spk_we, out_full;
    logic [FW-1:0] cfg_wdata, spk_wdata;
    logic          cfg_full, spk_full, out_we, arb_busy, cfg_ovf, spk_ovf;
    logic [FW-1:0] out_wdata;

    int checks   = 0;
    int failures = 0;
    int cfg_seq, spk_seq;

    typedef struct {
        logic          cw;
        logic [FW-1:0] cd;
        logic          sw;
        logic [FW-1:0] sd;
        logic          of;
        logic          owe;
        logic [FW-1:0] od;
        logic          cf;
        logic          sf;
        logic          busy;
    } vec_t;

    vec_t          vecs [11];
    logic [FW-1:0] exp3 [15];

    spk_out_arb #(.FW(FW), .DEPTH(2), .BURST(4)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_wdata(cfg_wdata), .cfg_full(cfg_full),
        .spk_we(spk_we), .spk_wdata(spk_wdata), .spk_full(spk_full),
        .out_full(out_full), .out_we(out_we), .out_wdata(out_wdata),
        .arb_busy(arb_busy), .cfg_ovf(cfg_ovf), .spk_ovf(spk_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        cfg_we = 1'b0; spk_we = 1'b0; out_full = 1'b0;
        cfg_wdata = {FW{1'b0}}; spk_wdata = {FW{1'b0}};
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out_we"},   64'(out_we),    64'(1'b0));
        chk({tag, "_out_wdata"},64'(out_wdata), 64'(1'b0));
        chk({tag, "_cfg_full"}, 64'(cfg_full),  64'(1'b0));
        chk({tag, "_spk_full"}, 64'(spk_full),  64'(1'b0));
        chk({tag, "_arb_busy"}, 64'(arb_busy),  64'(1'b0));
        chk({tag, "_cfg_ovf"},  64'(cfg_ovf),   64'(1'b0));
        chk({tag, "_spk_ovf"},  64'(spk_ovf),   64'(1'b0));
    endtask

    initial begin
        //              cw    cd       sw    sd        of    owe   od       cf    sf    busy
        vecs[0]  = '{1'b1, 59'h1, 1'b0, 59'h0,  1'b0, 1'b0, 59'h0,  1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 59'h0, 1'b0, 59'h0,  1'b0, 1'b1, 59'h1,  1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 59'h0, 1'b0, 59'h0,  1'b0, 1'b0, 59'h1,  1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 59'h2, 1'b1, 59'h10, 1'b1, 1'b0, 59'h1,  1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 59'h0, 1'b1, 59'h11, 1'b1, 1'b0, 59'h1,  1'b0, 1'b1, 1'b1};
        vecs[5]  = '{1'b1, 59'h3, 1'b0, 59'h0,  1'b0, 1'b1, 59'h2,  1'b0, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 59'h0, 1'b0, 59'h0,  1'b0, 1'b1, 59'h3,  1'b0, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 59'h0, 1'b0, 59'h0,  1'b0, 1'b1, 59'h10, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 59'h0, 1'b1, 59'h12, 1'b0, 1'b1, 59'h11, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 59'h0, 1'b0, 59'h0,  1'b0, 1'b1, 59'h12, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 59'h0, 1'b0, 59'h0,  1'b0, 1'b0, 59'h12, 1'b0, 1'b0, 1'b0};

        exp3 = '{59'h200, 59'h201, 59'h202, 59'h203, 59'h100, 59'h101, 59'h102, 59'h103,
                 59'h204, 59'h205, 59'h206, 59'h207, 59'h104, 59'h105, 59'h208};

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_all_zero("reset");

        // Per-cycle vector table: single-flit latency, back-pressure, mixed grants
        for (int i = 0; i < 11; i++) begin
            cfg_we = vecs[i].cw; cfg_wdata = vecs[i].cd;
            spk_we = vecs[i].sw; spk_wdata = vecs[i].sd;
            out_full = vecs[i].of;
            tick();
            chk($sformatf("vec%0d_out_we", i),   64'(out_we),    64'(vecs[i].owe));
            chk($sformatf("vec%0d_out_wdata", i),64'(out_wdata), 64'(vecs[i].od));
            chk($sformatf("vec%0d_cfg_full", i), 64'(cfg_full),  64'(vecs[i].cf));
            chk($sformatf("vec%0d_spk_full", i), 64'(spk_full),  64'(vecs[i].sf));
            chk($sformatf("vec%0d_arb_busy", i), 64'(arb_busy),  64'(vecs[i].busy));
        end

        // Mid-run reset with two flits queued and a sticky overflow pending
        idle_inputs();
        out_full = 1'b1;
        cfg_we = 1'b1; cfg_wdata = 59'h7; tick();
        cfg_wdata = 59'h8; tick();
        chk("rst_pre_cfg_full", 64'(cfg_full), 64'(1'b1));
        cfg_wdata = 59'h9; tick();
        cfg_we = 1'b0;
        chk("rst_pre_cfg_ovf", 64'(cfg_ovf), 64'(1'b1));
        chk("rst_pre_busy", 64'(arb_busy), 64'(1'b1));
        rst = 1'b1; out_full = 1'b0;
        tick();
        rst = 1'b0;
        chk_all_zero("midreset");
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("postrst%0d_out_we", i), 64'(out_we),   64'(1'b0));
            chk($sformatf("postrst%0d_busy", i),   64'(arb_busy), 64'(1'b0));
        end

        // Both FIFOs full under out_full, then bounded-burst drain with continuous refill
        do_reset();
        out_full = 1'b1;
        cfg_seq = 'h100; spk_seq = 'h200;
        for (int i = 0; i < 2; i++) begin
            cfg_we = 1'b1; cfg_wdata = FW'(cfg_seq); cfg_seq++;
            spk_we = 1'b1; spk_wdata = FW'(spk_seq); spk_seq++;
            tick();
        end
        cfg_we = 1'b0; spk_we = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("hold%0d_out_we", i),   64'(out_we),   64'(1'b0));
            chk($sformatf("hold%0d_cfg_full", i), 64'(cfg_full), 64'(1'b1));
            chk($sformatf("hold%0d_spk_full", i), 64'(spk_full), 64'(1'b1));
        end
        out_full = 1'b0;
        for (int c = 0; c < 16; c++) begin
            cfg_we = 1'b0; spk_we = 1'b0;
            if (c + 1 <= 12) begin
                if (!cfg_full) begin
                    cfg_we = 1'b1; cfg_wdata = FW'(cfg_seq); cfg_seq++;
                end
                if (!spk_full) begin
                    spk_we = 1'b1; spk_wdata = FW'(spk_seq); spk_seq++;
                end
            end
            tick();
            if (c < 15) begin
                chk($sformatf("burst%0d_out_we", c),    64'(out_we),    64'(1'b1));
                chk($sformatf("burst%0d_out_wdata", c), 64'(out_wdata), 64'(exp3[c]));
            end else begin
                chk("burst_end_out_we", 64'(out_we),   64'(1'b0));
                chk("burst_end_busy",   64'(arb_busy), 64'(1'b0));
            end
        end

        // Write while spike FIFO full: flit dropped, sticky overflow
        do_reset();
        out_full = 1'b1;
        spk_we = 1'b1; spk_wdata = 59'h50; tick();
        spk_wdata = 59'h51; tick();
        chk("ovf_spk_full", 64'(spk_full), 64'(1'b1));
        spk_wdata = 59'hAA; tick();
        spk_we = 1'b0; out_full = 1'b0;
        chk("ovf_spk_ovf_set", 64'(spk_ovf), 64'(1'b1));
        tick();
        chk("ovf_d0_we",   64'(out_we),    64'(1'b1));
        chk("ovf_d0_data", 64'(out_wdata), 64'(59'h50));
        tick();
        chk("ovf_d1_we",   64'(out_we),    64'(1'b1));
        chk("ovf_d1_data", 64'(out_wdata), 64'(59'h51));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("ovf_tail%0d_we", i),   64'(out_we),    64'(1'b0));
            chk($sformatf("ovf_tail%0d_data", i), 64'(out_wdata), 64'(59'h51));
        end
        chk("ovf_spk_ovf_sticky", 64'(spk_ovf), 64'(1'b1));
        chk("ovf_cfg_ovf_clear",  64'(cfg_ovf), 64'(1'b0));

        // Steady simultaneous push/pop on config FIFO at count 1
        do_reset();
        cfg_we = 1'b1; cfg_wdata = 59'h300; tick();
        chk("pp_start_busy", 64'(arb_busy), 64'(1'b1));
        for (int k = 0; k < 20; k++) begin
            cfg_we = 1'b1; cfg_wdata = FW'(32'h301 + k);
            tick();
            chk($sformatf("pp%0d_out_we", k),   64'(out_we),    64'(1'b1));
            chk($sformatf("pp%0d_out_wdata", k),64'(out_wdata), 64'(32'h300 + k));
            chk($sformatf("pp%0d_cfg_full", k), 64'(cfg_full),  64'(1'b0));
        end
        cfg_we = 1'b0;
        tick();
        chk("pp_last_we",   64'(out_we),    64'(1'b1));
        chk("pp_last_data", 64'(out_wdata), 64'(59'h314));
        tick();
        chk("pp_done_we",   64'(out_we),   64'(1'b0));
        chk("pp_done_busy", 64'(arb_busy), 64'(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
